// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit stepping Mini SRC fetch/execute and driving all datapath controls
module control_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR_Data,
    input  logic        ConFF_Out,
    input  logic        Stop,
    output logic        Run,
    output logic [7:0]  out_sel,
    output logic [11:0] in_sel,
    output logic [11:0] alu_ctl,
    output logic [2:0]  gsel,
    output logic        R_In,
    output logic        R_Out,
    output logic        BA_Out,
    output logic        Read,
    output logic        Write,
    output logic        IncPC
);
    typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam int C_OUT = 7, INPORT_OUT = 6, MDR_OUT = 5, PC_OUT = 4;
    localparam int ZLO_OUT = 3, ZHI_OUT = 2, LO_OUT = 1, HI_OUT = 0;
    localparam int CONFF_IN = 11, OUTPORT_IN = 10, INPORT_IN = 9, LO_IN = 8, HI_IN = 7, ZLO_IN = 6;
    localparam int ZHI_IN = 5, Y_IN = 4, IR_IN = 3, MAR_IN = 2, MDR_IN = 1, PC_IN = 0;
    localparam logic [2:0] G_RA = 3'b100, G_RB = 3'b010, G_RC = 3'b001;
    localparam logic [11:0] ALU_ADD = 12'h001;

    state_t state;
    logic [4:0] op;
    logic unused_ir;
    logic is_rr, is_imm, is_alu, is_md, is_nn, is_ld, is_ldi, is_st, is_mem, is_br;
    logic is_jr, is_in, is_out, is_mf, illegal, is_nop, is_halt, done;
    logic [11:0] alu_op;

    assign op        = IR_Data[31:27];
    assign unused_ir = ^IR_Data[26:0];
    assign is_rr     = op >= 5'd3 && op <= 5'd10;
    assign is_imm    = op >= 5'd11 && op <= 5'd13;
    assign is_alu    = is_rr || is_imm;
    assign is_md     = op == 5'd14 || op == 5'd15;
    assign is_nn     = op == 5'd16 || op == 5'd17;
    assign is_ld     = op == 5'd0;
    assign is_ldi    = op == 5'd1;
    assign is_st     = op == 5'd2;
    assign is_mem    = is_ld || is_ldi || is_st;
    assign is_br     = op == 5'd18;
    assign is_jr     = op == 5'd19;
    assign is_in     = op == 5'd21;
    assign is_out    = op == 5'd22;
    assign is_mf     = op == 5'd23 || op == 5'd24;
    assign illegal   = op == 5'd20 || op >= 5'd27;
    assign is_nop    = op == 5'd25 || (illegal && !HALT_ON_ILLEGAL);
    assign is_halt   = op == 5'd26 || (illegal && HALT_ON_ILLEGAL);

    // reg-reg ops occupy consecutive opcodes matching consecutive ALU bits
    always_comb
        alu_op = is_rr      ? 12'd1 << (op - 5'd3) :
                 op == 5'd11 ? ALU_ADD :
                 op == 5'd12 ? 12'h040 :
                 op == 5'd13 ? 12'h080 :
                 op == 5'd14 ? 12'h100 :
                 op == 5'd15 ? 12'h200 :
                 op == 5'd16 ? 12'h400 :
                 op == 5'd17 ? 12'h800 : 12'h000;

    assign done = (state == T2 && is_nop) ||
                  (state == T3 && (is_jr || is_in || is_out || is_mf)) ||
                  (state == T4 && is_nn) ||
                  (state == T5 && (is_alu || is_ldi)) ||
                  (state == T6 && (is_md || is_br)) ||
                  state == T7;

    always_ff @(posedge Clock or posedge Clear)
        if (Clear) state <= RST;
        else if (state == HALT || (state == T2 && is_halt)) state <= HALT;
        else if (state == RST || done) state <= Stop ? HALT : T0;
        else state <= state_t'(state + 4'd1);

    assign Run = state != RST && state != HALT;

    always_comb begin
        out_sel = '0;
        in_sel  = '0;
        alu_ctl = '0;
        gsel    = '0;
        R_In    = 1'b0;
        R_Out   = 1'b0;
        BA_Out  = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        IncPC   = 1'b0;
        case (state)
            T0: begin out_sel[PC_OUT] = 1'b1; in_sel[MAR_IN] = 1'b1; IncPC = 1'b1; end
            T1: begin Read = 1'b1; in_sel[MDR_IN] = 1'b1; end
            T2: begin out_sel[MDR_OUT] = 1'b1; in_sel[IR_IN] = 1'b1; end
            T3:
                if (is_alu) begin gsel = G_RB; R_Out = 1'b1; in_sel[Y_IN] = 1'b1; end
                else if (is_nn) begin gsel = G_RB; R_Out = 1'b1; alu_ctl = alu_op; in_sel[ZLO_IN] = 1'b1; end
                else if (is_md) begin gsel = G_RA; R_Out = 1'b1; in_sel[Y_IN] = 1'b1; end
                else if (is_mem) begin gsel = G_RB; BA_Out = 1'b1; in_sel[Y_IN] = 1'b1; end
                else if (is_br) begin gsel = G_RA; R_Out = 1'b1; in_sel[CONFF_IN] = 1'b1; end
                else if (is_jr) begin gsel = G_RA; R_Out = 1'b1; in_sel[PC_IN] = 1'b1; end
                else if (is_in) begin out_sel[INPORT_OUT] = 1'b1; gsel = G_RA; R_In = 1'b1; end
                else if (is_out) begin gsel = G_RA; R_Out = 1'b1; in_sel[OUTPORT_IN] = 1'b1; end
                else if (is_mf) begin
                    out_sel[HI_OUT] = op == 5'd23;
                    out_sel[LO_OUT] = op == 5'd24;
                    gsel = G_RA;
                    R_In = 1'b1;
                end
            T4:
                if (is_alu) begin
                    out_sel[C_OUT] = is_imm;
                    gsel = is_imm ? 3'b000 : G_RC;
                    R_Out = !is_imm;
                    alu_ctl = alu_op;
                    in_sel[ZLO_IN] = 1'b1;
                end
                else if (is_nn) begin out_sel[ZLO_OUT] = 1'b1; gsel = G_RA; R_In = 1'b1; end
                else if (is_md) begin
                    gsel = G_RB;
                    R_Out = 1'b1;
                    alu_ctl = alu_op;
                    in_sel[ZHI_IN] = 1'b1;
                    in_sel[ZLO_IN] = 1'b1;
                end
                else if (is_mem) begin out_sel[C_OUT] = 1'b1; alu_ctl = ALU_ADD; in_sel[ZLO_IN] = 1'b1; end
                else if (is_br) begin out_sel[PC_OUT] = 1'b1; in_sel[Y_IN] = 1'b1; end
            T5:
                if (is_alu || is_ldi) begin out_sel[ZLO_OUT] = 1'b1; gsel = G_RA; R_In = 1'b1; end
                else if (is_ld || is_st) begin out_sel[ZLO_OUT] = 1'b1; in_sel[MAR_IN] = 1'b1; end
                else if (is_md) begin out_sel[ZLO_OUT] = 1'b1; in_sel[LO_IN] = 1'b1; end
                else if (is_br) begin out_sel[C_OUT] = 1'b1; alu_ctl = ALU_ADD; in_sel[ZLO_IN] = 1'b1; end
            T6:
                if (is_md) begin out_sel[ZHI_OUT] = 1'b1; in_sel[HI_IN] = 1'b1; end
                else if (is_ld) begin Read = 1'b1; in_sel[MDR_IN] = 1'b1; end
                else if (is_st) begin gsel = G_RA; R_Out = 1'b1; in_sel[MDR_IN] = 1'b1; end
                else if (is_br) begin out_sel[ZLO_OUT] = 1'b1; in_sel[PC_IN] = ConFF_Out; end
            T7:
                if (is_ld) begin out_sel[MDR_OUT] = 1'b1; gsel = G_RA; R_In = 1'b1; end
                else if (is_st) Write = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of control_sequencer against a micro-program reference
module tb_control_sequencer;
    logic        Clock = 1'b0;
    logic        Clear = 1'b1;
    logic [31:0] IR_Data = '0;
    logic        ConFF_Out = 1'b0;
    logic        Stop = 1'b0;
    logic        Run, R_In, R_Out, BA_Out, Read, Write, IncPC;
    logic [7:0]  out_sel;
    logic [11:0] in_sel, alu_ctl;
    logic [2:0]  gsel;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR_Data(IR_Data), .ConFF_Out(ConFF_Out), .Stop(Stop),
        .Run(Run), .out_sel(out_sel), .in_sel(in_sel), .alu_ctl(alu_ctl), .gsel(gsel),
        .R_In(R_In), .R_Out(R_Out), .BA_Out(BA_Out), .Read(Read), .Write(Write), .IncPC(IncPC)
    );

    always #5 Clock = ~Clock;

    // word = {Run, out_sel, in_sel, alu_ctl, gsel, R_In, R_Out, BA_Out, Read, Write, IncPC}
    logic [41:0] obs;
    assign obs = {Run, out_sel, in_sel, alu_ctl, gsel, R_In, R_Out, BA_Out, Read, Write, IncPC};

    localparam logic [7:0] O_C = 8'h80, O_INP = 8'h40, O_MDR = 8'h20, O_PC = 8'h10;
    localparam logic [7:0] O_ZLO = 8'h08, O_ZHI = 8'h04, O_LO = 8'h02, O_HI = 8'h01;
    localparam logic [11:0] I_CONFF = 12'h800, I_OUTP = 12'h400, I_LO = 12'h100, I_HI = 12'h080;
    localparam logic [11:0] I_ZLO = 12'h040, I_ZHI = 12'h020, I_Y = 12'h010, I_IR = 12'h008;
    localparam logic [11:0] I_MAR = 12'h004, I_MDR = 12'h002, I_PC = 12'h001;
    localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
    localparam logic [5:0] F_RIN = 6'b100000, F_ROUT = 6'b010000, F_BA = 6'b001000;
    localparam logic [5:0] F_RD = 6'b000100, F_WR = 6'b000010, F_INC = 6'b000001;
    localparam logic [41:0] IDLE = '0;

    int checks = 0;
    int errors = 0;
    logic [11:0] alu_tab [32];
    logic [41:0] exp_q [$];

    function automatic logic [41:0] cw(input logic [7:0] o, input logic [11:0] i, input logic [11:0] a,
                                       input logic [2:0] g, input logic [5:0] f);
        return {1'b1, o, i, a, g, f};
    endfunction

    task automatic check(input string tag, input logic [41:0] got, input logic [41:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // expected per-cycle control words for one instruction, fetch included
    task automatic build(input logic [4:0] op, input bit cf);
        logic [11:0] a;
        a = alu_tab[op];
        exp_q = {};
        exp_q.push_back(cw(O_PC, I_MAR, '0, '0, F_INC));
        exp_q.push_back(cw('0, I_MDR, '0, '0, F_RD));
        exp_q.push_back(cw(O_MDR, I_IR, '0, '0, '0));
        if (op >= 3 && op <= 10) begin
            exp_q.push_back(cw('0, I_Y, '0, GB, F_ROUT));
            exp_q.push_back(cw('0, I_ZLO, a, GC, F_ROUT));
            exp_q.push_back(cw(O_ZLO, '0, '0, GA, F_RIN));
        end else if (op >= 11 && op <= 13) begin
            exp_q.push_back(cw('0, I_Y, '0, GB, F_ROUT));
            exp_q.push_back(cw(O_C, I_ZLO, a, '0, '0));
            exp_q.push_back(cw(O_ZLO, '0, '0, GA, F_RIN));
        end else if (op == 14 || op == 15) begin
            exp_q.push_back(cw('0, I_Y, '0, GA, F_ROUT));
            exp_q.push_back(cw('0, I_ZHI | I_ZLO, a, GB, F_ROUT));
            exp_q.push_back(cw(O_ZLO, I_LO, '0, '0, '0));
            exp_q.push_back(cw(O_ZHI, I_HI, '0, '0, '0));
        end else if (op == 16 || op == 17) begin
            exp_q.push_back(cw('0, I_ZLO, a, GB, F_ROUT));
            exp_q.push_back(cw(O_ZLO, '0, '0, GA, F_RIN));
        end else if (op <= 2) begin
            exp_q.push_back(cw('0, I_Y, '0, GB, F_BA));
            exp_q.push_back(cw(O_C, I_ZLO, 12'h001, '0, '0));
            if (op == 1) exp_q.push_back(cw(O_ZLO, '0, '0, GA, F_RIN));
            else begin
                exp_q.push_back(cw(O_ZLO, I_MAR, '0, '0, '0));
                if (op == 0) begin
                    exp_q.push_back(cw('0, I_MDR, '0, '0, F_RD));
                    exp_q.push_back(cw(O_MDR, '0, '0, GA, F_RIN));
                end else begin
                    exp_q.push_back(cw('0, I_MDR, '0, GA, F_ROUT));
                    exp_q.push_back(cw('0, '0, '0, '0, F_WR));
                end
            end
        end else if (op == 18) begin
            exp_q.push_back(cw('0, I_CONFF, '0, GA, F_ROUT));
            exp_q.push_back(cw(O_PC, I_Y, '0, '0, '0));
            exp_q.push_back(cw(O_C, I_ZLO, 12'h001, '0, '0));
            exp_q.push_back(cw(O_ZLO, cf ? I_PC : 12'h000, '0, '0, '0));
        end else if (op == 19) exp_q.push_back(cw('0, I_PC, '0, GA, F_ROUT));
        else if (op == 21) exp_q.push_back(cw(O_INP, '0, '0, GA, F_RIN));
        else if (op == 22) exp_q.push_back(cw('0, I_OUTP, '0, GA, F_ROUT));
        else if (op == 23) exp_q.push_back(cw(O_HI, '0, '0, GA, F_RIN));
        else if (op == 24) exp_q.push_back(cw(O_LO, '0, '0, GA, F_RIN));
    endtask

    // entered at a falling edge with the DUT in T0; leaves at the falling edge after the instruction
    task automatic run_instr(input logic [31:0] ir, input bit cf, input bit stp, input string name);
        int n;
        IR_Data = ir;
        ConFF_Out = cf;
        Stop = stp;
        build(ir[31:27], cf);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_t%0d", name, i), obs, exp_q[i]);
            @(negedge Clock);
        end
        if (stp || ir[31:27] == 5'd26) check($sformatf("%s_halt", name), obs, IDLE);
        else check($sformatf("%s_next_t0", name), obs, cw(O_PC, I_MAR, '0, '0, F_INC));
        Stop = 1'b0;
    endtask

    initial begin
        logic [4:0] ops [26];
        logic [31:0] r;
        foreach (alu_tab[i]) alu_tab[i] = '0;
        alu_tab[3] = 12'h001; alu_tab[4] = 12'h002; alu_tab[5] = 12'h004; alu_tab[6] = 12'h008;
        alu_tab[7] = 12'h010; alu_tab[8] = 12'h020; alu_tab[9] = 12'h040; alu_tab[10] = 12'h080;
        alu_tab[11] = 12'h001; alu_tab[12] = 12'h040; alu_tab[13] = 12'h080;
        alu_tab[14] = 12'h100; alu_tab[15] = 12'h200; alu_tab[16] = 12'h400; alu_tab[17] = 12'h800;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
                5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd24, 5'd25};

        repeat (3) @(negedge Clock);
        check("reset_idle", obs, IDLE);
        Clear = 1'b0;
        @(negedge Clock);

        run_instr(32'h1800_0000, 1'b0, 1'b0, "add");
        run_instr(32'h7000_0000, 1'b0, 1'b0, "mul");
        run_instr(32'h1000_0000, 1'b0, 1'b0, "st");
        run_instr(32'h0000_0000, 1'b0, 1'b0, "ld");
        run_instr(32'h9000_0000, 1'b0, 1'b0, "br_nt");
        run_instr(32'h9000_0000, 1'b1, 1'b0, "br_t");
        run_instr(32'hC800_0000, 1'b0, 1'b0, "nop");
        run_instr(32'hF800_0000, 1'b0, 1'b0, "illegal31");
        run_instr(32'hA000_0000, 1'b0, 1'b0, "illegal20");

        for (int k = 0; k < 60; k++) begin
            r = $urandom();
            run_instr({ops[$urandom_range(0, 25)], r[26:0]}, 1'($urandom_range(0, 1)), 1'b0,
                      $sformatf("rnd%0d", k));
        end

        IR_Data = 32'h1800_0000;
        repeat (4) @(negedge Clock);
        check("add_t4_before_clear", obs, cw('0, I_ZLO, 12'h001, GC, F_ROUT));
        #1 Clear = 1'b1;
        #1 check("clear_mid_t4", obs, IDLE);
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
        check("restart_t0", obs, cw(O_PC, I_MAR, '0, '0, F_INC));

        run_instr(32'h2000_0000, 1'b0, 1'b1, "stop_sub");
        repeat (3) @(negedge Clock);
        check("stop_holds_halt", obs, IDLE);

        Clear = 1'b1;
        Stop = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);
        check("stop_in_reset_halt", obs, IDLE);
        Stop = 1'b0;
        repeat (2) @(negedge Clock);
        check("stop_in_reset_stays", obs, IDLE);
        Clear = 1'b1;
        @(negedge Clock);
        Clear = 1'b0;
        @(negedge Clock);

        run_instr(32'hD000_0000, 1'b0, 1'b0, "halt");
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            check($sformatf("halt_hold%0d", k), obs, IDLE);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
